// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide datapath.
package alu_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned BR_W     = 2;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;

  // R-type funct codes
  localparam logic [FN_W-1:0] FN_ADD   = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB   = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND   = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR    = 6'b100101;
  localparam logic [FN_W-1:0] FN_XOR   = 6'b100110;
  localparam logic [FN_W-1:0] FN_NOR   = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT   = 6'b101010;
  localparam logic [FN_W-1:0] FN_SLTU  = 6'b101011;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FN_W-1:0] FN_MTHI  = 6'b010001;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FN_W-1:0] FN_MTLO  = 6'b010011;
  localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FN_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FN_W-1:0] FN_DIV   = 6'b011010;
  localparam logic [FN_W-1:0] FN_DIVU  = 6'b011011;

  // Branch compare kinds
  localparam logic [BR_W-1:0] BR_NONE = 2'b00;
  localparam logic [BR_W-1:0] BR_EQ   = 2'b01;
  localparam logic [BR_W-1:0] BR_NE   = 2'b10;
  localparam logic [BR_W-1:0] BR_LT   = 2'b11;

  // Multiply/divide engine state
  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;

  // Engine op kind; order matches funct[1:0] of MULT/MULTU/DIV/DIVU
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// Instruction/result bundle between control unit and the ALU.
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 17
);
  import alu_pkg::*;

  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic [FN_W-1:0]     fn;
  logic [WIDTH-1:0]    rs;
  logic [WIDTH-1:0]    rtwire;
  logic [IMM_W-1:0]    imm;
  logic                alusrc;
  logic [BR_W-1:0]     brtype;
  logic [WIDTH-1:0]    alu_result;
  logic                carry_out;
  logic                brtrue;
  logic                busy;
  logic                done;

  modport master (
    output start, opcode, fn, rs, rtwire, imm, alusrc, brtype,
    input  alu_result, carry_out, brtrue, busy, done
  );

  modport slave (
    input  start, opcode, fn, rs, rtwire, imm, alusrc, brtype,
    output alu_result, carry_out, brtrue, busy, done
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_c,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, neg_q, rneg_q, dz_q, done_q;

  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_add, div_rsh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;

  // Operand magnitudes and signs captured on acceptance
  always_comb begin
    sgn_op = (op == MD_MULT) || (op == MD_DIV);
    sa     = sgn_op & a[WIDTH-1];
    sb     = sgn_op & b[WIDTH-1];
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_add = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rsh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge  = (div_rsh >= {1'b0, opnd_q});
    div_sub = div_rsh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_sub : div_rsh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_add[WIDTH:1];
      step_lo = {mul_add[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = -prod;
    quo = dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    rem = rneg_q ? -acc_hi_q : acc_hi_q;
    fix_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div_q ? quo : prod[WIDTH-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Iteration datapath: load on accept, step while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            cnt_q    <= CNT_LAST;
            acc_hi_q <= '0;
            neg_q    <= sa ^ sb;
            if ((op == MD_DIV) || (op == MD_DIVU)) begin
              is_div_q <= 1'b1;
              acc_lo_q <= mag_a;
              opnd_q   <= mag_b;
              rneg_q   <= sa;
              dz_q     <= (b == '0);
            end else begin
              is_div_q <= 1'b0;
              acc_lo_q <= mag_b;
              opnd_q   <= mag_a;
              rneg_q   <= 1'b0;
              dz_q     <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: engine result in FIX, MTHI/MTLO only when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      if (state_q == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state_q == IDLE) begin
        if (mthi_we) hi_q <= mt_data;
        if (mtlo_we) lo_q <= mt_data;
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: rtl/alu_muldiv.sv
// Single-cycle ALU with branch compare plus multi-cycle mul/div engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  alu_muldiv_if.slave bus
);

  logic [IMM_W-1:0] imm_v;
  logic [WIDTH-1:0] b_op, hi, lo, alu_c;
  logic [WIDTH:0]   sum;
  logic             is_r, is_md, accept, busy, done, br_c;
  logic             mthi_we, mtlo_we;
  md_op_e           md_op;

  // Operand B select and shared adder
  assign imm_v = bus.imm;
  assign b_op  = bus.alusrc ? WIDTH'($signed(imm_v)) : bus.rtwire;
  assign sum   = {1'b0, bus.rs} + {1'b0, b_op};

  // Decode for engine launch and HI/LO moves
  assign is_r    = (bus.opcode == OP_RTYPE);
  assign is_md   = is_r && (bus.fn[5:2] == 4'b0110);
  assign md_op   = md_op_e'(bus.fn[1:0]);
  assign accept  = bus.start & ~busy;
  assign mthi_we = accept & is_r & (bus.fn == FN_MTHI);
  assign mtlo_we = accept & is_r & (bus.fn == FN_MTLO);

  // Combinational result mux; unlisted ops and engine ops give zero
  always_comb begin
    alu_c = '0;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.fn)
          FN_ADD:  alu_c = sum[WIDTH-1:0];
          FN_SUB:  alu_c = bus.rs - b_op;
          FN_AND:  alu_c = bus.rs & b_op;
          FN_OR:   alu_c = bus.rs | b_op;
          FN_XOR:  alu_c = bus.rs ^ b_op;
          FN_NOR:  alu_c = ~(bus.rs | b_op);
          FN_SLT:  alu_c = WIDTH'($signed(bus.rs) < $signed(b_op));
          FN_SLTU: alu_c = WIDTH'(bus.rs < b_op);
          FN_MFHI: alu_c = hi;
          FN_MFLO: alu_c = lo;
          default: alu_c = '0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_c = sum[WIDTH-1:0];
      OP_ANDI: alu_c = bus.rs & b_op;
      OP_ORI:  alu_c = bus.rs | b_op;
      OP_XORI: alu_c = bus.rs ^ b_op;
      default: alu_c = '0;
    endcase
  end

  // Branch decision on rs vs rt register value
  always_comb begin
    br_c = 1'b0;
    case (bus.brtype)
      BR_EQ:   br_c = (bus.rs == bus.rtwire);
      BR_NE:   br_c = (bus.rs != bus.rtwire);
      BR_LT:   br_c = ($signed(bus.rs) < $signed(bus.rtwire));
      default: br_c = 1'b0;
    endcase
  end

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_c (accept & is_md),
    .op      (md_op),
    .a       (bus.rs),
    .b       (bus.rtwire),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .mt_data (bus.rs),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  assign bus.alu_result = alu_c;
  assign bus.carry_out  = sum[WIDTH];
  assign bus.brtrue     = br_c;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: combinational vector table plus mul/div sequences.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IMM_W = 17;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

  alu_muldiv #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [16:0] imm;
    logic        alusrc;
    logic [1:0]  brtype;
    logic [31:0] exp_res;
    logic        exp_carry;
    logic        exp_br;
  } vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } md_vec_t;

  vec_t    vecs[$];
  md_vec_t mdv[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic addv(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [16:0] imm, input logic alusrc,
                      input logic [1:0] br, input logic [31:0] er, input logic ec, input logic eb);
    vec_t v;
    v.opcode = opc; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm; v.alusrc = alusrc;
    v.brtype = br; v.exp_res = er; v.exp_carry = ec; v.exp_br = eb;
    vecs.push_back(v);
  endtask

  task automatic addmd(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    md_vec_t m;
    m.fn = fn; m.a = a; m.b = b; m.exp_hi = eh; m.exp_lo = el;
    mdv.push_back(m);
  endtask

  task automatic set_op(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [16:0] imm, input logic alusrc,
                        input logic [1:0] br, input logic st);
    bus.opcode = opc; bus.fn = fn; bus.rs = rs; bus.rtwire = rt; bus.imm = imm;
    bus.alusrc = alusrc; bus.brtype = br; bus.start = st;
  endtask

  // Present a mul/div instruction for one edge; returns at the negedge after E0
  task automatic md_start(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    set_op(OP_RTYPE, fn, a, b, 17'h0, 1'b0, BR_NONE, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges with busy high, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.start = 1'b0; bus.opcode = OP_RTYPE; bus.alusrc = 1'b0;
    bus.fn = FN_MFHI;
    #1 h = bus.alu_result;
    bus.fn = FN_MFLO;
    #1 l = bus.alu_result;
  endtask

  initial begin
    int n;
    logic saw;
    logic [31:0] h, l;

    // Combinational vectors
    addv(OP_RTYPE, FN_ADD,  32'h5,        32'h7,        17'h0, 0, BR_NONE, 32'hC,        0, 0);
    addv(OP_RTYPE, FN_SUB,  32'h5,        32'h7,        17'h0, 0, BR_NONE, 32'hFFFFFFFE, 0, 0);
    addv(OP_RTYPE, FN_ADD,  32'hFFFFFFFF, 32'h1,        17'h0, 0, BR_NONE, 32'h0,        1, 0);
    addv(OP_RTYPE, FN_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 17'h0, 0, BR_NONE, 32'h00F000F0, 1, 0);
    addv(OP_RTYPE, FN_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 17'h0, 0, BR_NONE, 32'hFFF0FFF0, 1, 0);
    addv(OP_RTYPE, FN_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 17'h0, 0, BR_NONE, 32'hFF00FF00, 1, 0);
    addv(OP_RTYPE, FN_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 17'h0, 0, BR_NONE, 32'h000F000F, 1, 0);
    addv(OP_RTYPE, FN_SLT,  32'hFFFFFFFF, 32'h1,        17'h0, 0, BR_NONE, 32'h1,        1, 0);
    addv(OP_RTYPE, FN_SLTU, 32'hFFFFFFFF, 32'h1,        17'h0, 0, BR_NONE, 32'h0,        1, 0);
    addv(OP_ADDI,  6'h0,    32'h10,       32'h0,        17'h1FFFF, 1, BR_NONE, 32'hF,    1, 0);
    addv(OP_ANDI,  6'h0,    32'h12345678, 32'h0,        17'h0FF0F, 1, BR_NONE, 32'h00005608, 0, 0);
    addv(OP_ORI,   6'h0,    32'h12340000, 32'h0,        17'h000FF, 1, BR_NONE, 32'h123400FF, 0, 0);
    addv(OP_XORI,  6'h0,    32'hFFFF0000, 32'h0,        17'h1FFFF, 1, BR_NONE, 32'h0000FFFF, 1, 0);
    addv(OP_LW,    6'h0,    32'h100,      32'h0,        17'h1FFFC, 1, BR_NONE, 32'hFC,       1, 0);
    addv(6'b111111, FN_ADD, 32'h5,        32'h7,        17'h0, 0, BR_NONE, 32'h0,        0, 0);
    addv(OP_RTYPE, 6'b000001, 32'h5,      32'h7,        17'h0, 0, BR_NONE, 32'h0,        0, 0);
    addv(6'b000100, 6'h0,   32'h7,        32'h7,        17'h0, 0, BR_EQ,   32'h0,        0, 1);
    addv(6'b000100, 6'h0,   32'h7,        32'h7,        17'h0, 0, BR_NE,   32'h0,        0, 0);
    addv(6'b000100, 6'h0,   32'h7,        32'h8,        17'h0, 0, BR_NE,   32'h0,        0, 1);
    addv(6'b000100, 6'h0,   32'hFFFFFFFF, 32'h0,        17'h0, 0, BR_LT,   32'h0,        0, 1);
    addv(6'b000100, 6'h0,   32'h0,        32'hFFFFFFFF, 17'h0, 0, BR_LT,   32'h0,        0, 0);
    addv(6'b000100, 6'h0,   32'h7,        32'h7,        17'h0, 0, BR_NONE, 32'h0,        0, 0);

    // Mul/div vectors: {fn, a, b, HI, LO}
    addmd(FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    addmd(FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    addmd(FN_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    addmd(FN_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    addmd(FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    addmd(FN_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    addmd(FN_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2);
    addmd(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    addmd(FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

    // Reset
    rst = 1'b1;
    set_op(OP_RTYPE, 6'h0, 32'h0, 32'h0, 17'h0, 1'b0, BR_NONE, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    read_hilo(h, l);
    check("reset_hi", 64'(h), 64'd0);
    check("reset_lo", 64'(l), 64'd0);

    // Combinational table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_op(vecs[i].opcode, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].imm,
             vecs[i].alusrc, vecs[i].brtype, 1'b0);
      #1;
      check($sformatf("vec%0d_res", i),   64'(bus.alu_result), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_carry", i), 64'(bus.carry_out),  64'(vecs[i].exp_carry));
      check($sformatf("vec%0d_br", i),    64'(bus.brtrue),     64'(vecs[i].exp_br));
    end

    // MTHI / MTLO
    @(negedge clk);
    set_op(OP_RTYPE, FN_MTHI, 32'hA5A5, 32'h0, 17'h0, 1'b0, BR_NONE, 1'b1);
    @(negedge clk);
    set_op(OP_RTYPE, FN_MTLO, 32'h5A5A, 32'h0, 17'h0, 1'b0, BR_NONE, 1'b1);
    @(negedge clk);
    read_hilo(h, l);
    check("mthi", 64'(h), 64'h0000A5A5);
    check("mtlo", 64'(l), 64'h00005A5A);

    // MULT -3 x 7: busy window, done pulse, result
    @(negedge clk);
    md_start(FN_MULT, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    check("mult_busy_cycles", 64'(n), 64'd33);
    check("mult_done", 64'(bus.done), 64'd1);
    read_hilo(h, l);
    check("mult_hi", 64'(h), 64'hFFFFFFFF);
    check("mult_lo", 64'(l), 64'hFFFFFFEB);

    // Back-to-back MULTU launched in the done cycle; MTLO while busy is ignored
    md_start(FN_MULTU, 32'd6, 32'd7);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    @(negedge clk);
    set_op(OP_RTYPE, FN_MTLO, 32'h1234, 32'h0, 17'h0, 1'b0, BR_NONE, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    read_hilo(h, l);
    check("mflo_busy_old", 64'(l), 64'hFFFFFFEB);
    check("mfhi_busy_old", 64'(h), 64'hFFFFFFFF);
    wait_idle(n);
    check("b2b_busy_cycles", 64'(n), 64'd31);
    check("b2b_done", 64'(bus.done), 64'd1);
    read_hilo(h, l);
    check("multu_hi", 64'(h), 64'd0);
    check("multu_lo", 64'(l), 64'd42);
    @(negedge clk);
    check("done_clear", 64'(bus.done), 64'd0);

    // Mul/div table
    for (int i = 0; i < mdv.size(); i++) begin
      md_start(mdv[i].fn, mdv[i].a, mdv[i].b);
      wait_idle(n);
      check($sformatf("md%0d_cycles", i), 64'(n), 64'd33);
      check($sformatf("md%0d_done", i), 64'(bus.done), 64'd1);
      read_hilo(h, l);
      check($sformatf("md%0d_hi", i), 64'(h), 64'(mdv[i].exp_hi));
      check($sformatf("md%0d_lo", i), 64'(l), 64'(mdv[i].exp_lo));
    end

    // Reset at cycle 10 of a MULT aborts it
    @(negedge clk);
    md_start(FN_MULT, 32'h12345, 32'h678);
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw = 1'b1;
    end
    check("abort_no_done", 64'(saw), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);
    read_hilo(h, l);
    check("abort_hi", 64'(h), 64'd0);
    check("abort_lo", 64'(l), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
